// File: rtl/card_layer_arbiter.sv
// Shares one card-sprite renderer between NUM_SLOTS card slots: a double-buffered slot table
// with a per-frame commit, and a per-pixel fixed-priority hit selection with a registered result.
module card_layer_arbiter #(
  parameter int NUM_SLOTS = 16,
  parameter int SLOT_W    = 4,
  parameter int X_WIDTH   = 30,
  parameter int Y_WIDTH   = 50
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [9:0]        i_x_cnt,
  input  logic [9:0]        i_y_cnt,
  input  logic              i_frame_start,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [SLOT_W-1:0] i_wr_slot,
  input  logic [9:0]        i_wr_x,
  input  logic [9:0]        i_wr_y,
  input  logic [2:0]        i_wr_color,
  output logic [9:0]        o_spr_x_pin,
  output logic [9:0]        o_spr_y_pin,
  output logic [2:0]        o_spr_color,
  output logic              o_spr_hit,
  output logic [SLOT_W-1:0] o_spr_slot,
  output logic [9:0]        o_x_cnt_d,
  output logic [9:0]        o_y_cnt_d,
  output logic              o_committed
);

  logic [9:0] r_sh_x [NUM_SLOTS];
  logic [9:0] r_sh_y [NUM_SLOTS];
  logic [2:0] r_sh_c [NUM_SLOTS];
  logic [9:0] r_ac_x [NUM_SLOTS];
  logic [9:0] r_ac_y [NUM_SLOTS];
  logic [2:0] r_ac_c [NUM_SLOTS];
  logic       r_dirty;

  logic                 w_wr_fire;
  logic                 w_slot_ok;
  logic                 w_commit;
  logic [NUM_SLOTS-1:0] w_hit;
  logic                 w_sel_hit;
  logic [SLOT_W-1:0]    w_sel_idx;

  // Writes are refused in the commit cycle so shadow and active never change together.
  assign o_wr_ready = i_rst_n && !i_frame_start;
  assign w_wr_fire  = i_wr_valid && o_wr_ready;
  assign w_slot_ok  = ({1'b0, i_wr_slot} < (SLOT_W+1)'(NUM_SLOTS));
  assign w_commit   = i_frame_start && r_dirty;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        r_sh_x[s] <= '0;
        r_sh_y[s] <= '0;
        r_sh_c[s] <= '0;
        r_ac_x[s] <= '0;
        r_ac_y[s] <= '0;
        r_ac_c[s] <= '0;
      end
      r_dirty <= 1'b0;
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (w_wr_fire && i_wr_slot == SLOT_W'(s)) begin
          r_sh_x[s] <= i_wr_x;
          r_sh_y[s] <= i_wr_y;
          r_sh_c[s] <= i_wr_color;
        end
        if (w_commit) begin
          r_ac_x[s] <= r_sh_x[s];
          r_ac_y[s] <= r_sh_y[s];
          r_ac_c[s] <= r_sh_c[s];
        end
      end
      if (w_commit)
        r_dirty <= 1'b0;
      else if (w_wr_fire && w_slot_ok)
        r_dirty <= 1'b1;
    end
  end

  // Upper bounds are formed 11 bits wide so a sprite near the right/bottom edge clips, not wraps.
  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_hit
      logic [10:0] w_x_hi;
      logic [10:0] w_y_hi;
      assign w_x_hi = {1'b0, r_ac_x[gi]} + 11'(X_WIDTH);
      assign w_y_hi = {1'b0, r_ac_y[gi]} + 11'(Y_WIDTH);
      assign w_hit[gi] = r_ac_c[gi][2]
                      && (i_x_cnt >= r_ac_x[gi]) && ({1'b0, i_x_cnt} <= w_x_hi)
                      && (i_y_cnt >= r_ac_y[gi]) && ({1'b0, i_y_cnt} <= w_y_hi);
    end
  endgenerate

  // Ascending scan: the last (highest-index) hit overrides lower ones.
  always_comb begin
    w_sel_hit = 1'b0;
    w_sel_idx = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (w_hit[s]) begin
        w_sel_hit = 1'b1;
        w_sel_idx = SLOT_W'(s);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_spr_x_pin <= '0;
      o_spr_y_pin <= '0;
      o_spr_color <= '0;
      o_spr_hit   <= 1'b0;
      o_spr_slot  <= '0;
      o_x_cnt_d   <= '0;
      o_y_cnt_d   <= '0;
      o_committed <= 1'b0;
    end else begin
      o_spr_hit   <= w_sel_hit;
      o_spr_slot  <= w_sel_hit ? w_sel_idx : '0;
      o_spr_x_pin <= w_sel_hit ? r_ac_x[w_sel_idx] : '0;
      o_spr_y_pin <= w_sel_hit ? r_ac_y[w_sel_idx] : '0;
      o_spr_color <= w_sel_hit ? r_ac_c[w_sel_idx] : '0;
      o_x_cnt_d   <= i_x_cnt;
      o_y_cnt_d   <= i_y_cnt;
      o_committed <= w_commit;
    end
  end

endmodule
